// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : muldiv_seq_if
//  Purpose  : Pipeline-side bundle for the multi-cycle multiply/divide unit.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             AnyStall;
   logic             Start_ME;
   logic [1:0]       MdOp_ME;
   logic             RdHi_ME;
   logic             RdLo_ME;
   logic [WIDTH-1:0] SrcA_ME;
   logic [WIDTH-1:0] SrcB_ME;
   logic [WIDTH-1:0] MdOut_EX;
   logic             Busy_EX;
   logic             Stall_EX;

   modport master (
      output flush, AnyStall, Start_ME, MdOp_ME, RdHi_ME, RdLo_ME, SrcA_ME, SrcB_ME,
      input  MdOut_EX, Busy_EX, Stall_EX
   );

   modport slave (
      input  flush, AnyStall, Start_ME, MdOp_ME, RdHi_ME, RdLo_ME, SrcA_ME, SrcB_ME,
      output MdOut_EX, Busy_EX, Stall_EX
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : muldiv_seq
//  Purpose  : Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input wire          clk,
   input wire          rst_n,
   muldiv_seq_if.slave md
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_count;
   logic             r_is_div;
   logic             r_is_signed;
   logic             r_sa;
   logic             r_sb;
   logic [WIDTH-1:0] r_ph;
   logic [WIDTH-1:0] r_pl;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_orig_a;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_accept;
   logic             w_signed_in;
   logic             w_sa_in;
   logic             w_sb_in;
   logic [WIDTH-1:0] w_ma_in;
   logic [WIDTH-1:0] w_mb_in;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_ph_step;
   logic [WIDTH-1:0] w_pl_step;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic             w_neg_q;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;
   logic             w_div_zero;
   logic [WIDTH-1:0] w_hi_res;
   logic [WIDTH-1:0] w_lo_res;

   assign w_accept    = (r_state == S_IDLE) & md.Start_ME & ~md.AnyStall & ~md.flush;
   assign w_signed_in = ~md.MdOp_ME[0];
   assign w_sa_in     = w_signed_in & md.SrcA_ME[WIDTH-1];
   assign w_sb_in     = w_signed_in & md.SrcB_ME[WIDTH-1];
   assign w_ma_in     = w_sa_in ? -md.SrcA_ME : md.SrcA_ME;
   assign w_mb_in     = w_sb_in ? -md.SrcB_ME : md.SrcB_ME;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_RUN;
         S_RUN: begin
            if (md.flush) begin
               w_state_nxt = S_IDLE;
            end else if (r_count == '0) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // One iteration: shift-add for multiply (r_ph:r_pl is the product window),
   // restoring step for divide (r_ph remainder, r_pl dividend/quotient).
   always_comb begin
      w_sum   = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_mcand} : '0);
      w_shift = {r_ph, r_pl[WIDTH-1]};
      w_trial = w_shift - {1'b0, r_mcand};
      if (r_is_div) begin
         w_ph_step = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
         w_pl_step = {r_pl[WIDTH-2:0], ~w_trial[WIDTH]};
      end else begin
         w_ph_step = w_sum[WIDTH:1];
         w_pl_step = {w_sum[0], r_pl[WIDTH-1:1]};
      end
   end

   // Sign fix-up; remainder follows the dividend so division truncates toward zero.
   always_comb begin
      w_prod     = {r_ph, r_pl};
      w_neg_q    = r_is_signed & (r_sa ^ r_sb);
      w_prod_fix = w_neg_q ? -w_prod : w_prod;
      w_quot     = w_neg_q ? -r_pl : r_pl;
      w_rem      = (r_is_signed & r_sa) ? -r_ph : r_ph;
      w_div_zero = (r_mcand == '0);
      if (!r_is_div) begin
         w_hi_res = w_prod_fix[2*WIDTH-1:WIDTH];
         w_lo_res = w_prod_fix[WIDTH-1:0];
      end else if (w_div_zero) begin
         w_hi_res = r_orig_a;
         w_lo_res = '1;
      end else begin
         w_hi_res = w_rem;
         w_lo_res = w_quot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count     <= '0;
         r_is_div    <= 1'b0;
         r_is_signed <= 1'b0;
         r_sa        <= 1'b0;
         r_sb        <= 1'b0;
         r_ph        <= '0;
         r_pl        <= '0;
         r_mcand     <= '0;
         r_orig_a    <= '0;
      end else if (w_accept) begin
         r_count     <= CW'(WIDTH - 1);
         r_is_div    <= md.MdOp_ME[1];
         r_is_signed <= w_signed_in;
         r_sa        <= w_sa_in;
         r_sb        <= w_sb_in;
         r_ph        <= '0;
         r_pl        <= w_ma_in;
         r_mcand     <= w_mb_in;
         r_orig_a    <= md.SrcA_ME;
      end else if (r_state == S_RUN) begin
         r_count <= r_count - CW'(1);
         r_ph    <= w_ph_step;
         r_pl    <= w_pl_step;
      end
   end

   // A flush landing on the FIX cycle still discards the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if ((r_state == S_FIX) && !md.flush) begin
         r_hi <= w_hi_res;
         r_lo <= w_lo_res;
      end
   end

   assign md.MdOut_EX = md.RdHi_ME ? r_hi : r_lo;
   assign md.Busy_EX  = (r_state == S_RUN) || (r_state == S_FIX);
   assign md.Stall_EX = md.Busy_EX & (md.Start_ME | md.RdHi_ME | md.RdLo_ME);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : tb_muldiv_seq
//  Purpose  : Scoreboard bench for muldiv_seq latency, results, stalls, aborts.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_muldiv_seq;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   logic [63:0] sb[$];

   muldiv_seq_if #(.WIDTH(32)) md();

   muldiv_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .md    (md)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb_v;
      longint      q;
      longint      r;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] res;
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      ua   = {32'h0, a};
      ub   = {32'h0, b};
      case (op)
         2'b00: res = sa * sb_v;
         2'b01: res = ua * ub;
         2'b10: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else begin
               q   = sa / sb_v;
               r   = sa % sb_v;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else res = {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
      return res;
   endfunction

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      md.RdHi_ME = 1'b1;
      #1 hi = md.MdOut_EX;
      md.RdHi_ME = 1'b0;
      md.RdLo_ME = 1'b1;
      #1 lo = md.MdOut_EX;
      md.RdLo_ME = 1'b0;
   endtask

   // Issues one op at the current cycle, pushes the expectation, waits out Busy_EX.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input logic stall_busy, input string name);
      int          busy_cycles;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [63:0] e;
      sb.push_back(exp);
      md.Start_ME = 1'b1;
      md.MdOp_ME  = op;
      md.SrcA_ME  = a;
      md.SrcB_ME  = b;
      @(posedge clk); #1;
      md.Start_ME = 1'b0;
      md.SrcA_ME  = $urandom;
      md.SrcB_ME  = $urandom;
      md.AnyStall = stall_busy;
      busy_cycles = 0;
      while (md.Busy_EX === 1'b1 && busy_cycles < 100) begin
         busy_cycles++;
         @(posedge clk); #1;
      end
      md.AnyStall = 1'b0;
      vectors++;
      if (busy_cycles !== 33) begin
         miscompares++;
         $display("FAIL %s busy_cycles: got %0d, expected 33", name, busy_cycles);
      end
      read_hilo(hi, lo);
      e = sb.pop_front();
      vectors++;
      if (hi !== e[63:32]) begin
         miscompares++;
         $display("FAIL %s hi: got %h, expected %h", name, hi, e[63:32]);
      end
      vectors++;
      if (lo !== e[31:0]) begin
         miscompares++;
         $display("FAIL %s lo: got %h, expected %h", name, lo, e[31:0]);
      end
   endtask

   task automatic test_reset();
      logic [31:0] hi;
      logic [31:0] lo;
      rst_n = 1'b0;
      md.flush = 1'b0; md.AnyStall = 1'b0; md.Start_ME = 1'b0; md.MdOp_ME = 2'b00;
      md.RdHi_ME = 1'b0; md.RdLo_ME = 1'b0; md.SrcA_ME = '0; md.SrcB_ME = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (md.Busy_EX !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy: got %b, expected 0", md.Busy_EX);
      end
      md.Start_ME = 1'b1;
      md.RdLo_ME  = 1'b1;
      #1;
      vectors++;
      if (md.Stall_EX !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_stall: got %b, expected 0", md.Stall_EX);
      end
      md.Start_ME = 1'b0;
      md.RdLo_ME  = 1'b0;
      read_hilo(hi, lo);
      vectors++;
      if (hi !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_hi: got %h, expected 00000000", hi);
      end
      vectors++;
      if (lo !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_lo: got %h, expected 00000000", lo);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mul_div_basic();
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, "multu_max");
      run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, "mult_neg");
      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "div_neg");
   endtask

   task automatic test_div_special();
      run_op(2'b11, 32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF, 1'b0, "divu_zero");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, "div_ovf");
   endtask

   task automatic test_read_stall();
      int          stall_cycles;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [63:0] e;
      sb.push_back(64'h0000_0000_0000_002A);
      md.Start_ME = 1'b1;
      md.MdOp_ME  = 2'b01;
      md.SrcA_ME  = 32'd6;
      md.SrcB_ME  = 32'd7;
      md.RdLo_ME  = 1'b1;
      #1;
      vectors++;
      if (md.MdOut_EX !== 32'h8000_0000) begin
         miscompares++;
         $display("FAIL start_read_old_lo: got %h, expected 80000000", md.MdOut_EX);
      end
      @(posedge clk); #1;
      md.Start_ME = 1'b0;
      stall_cycles = 0;
      while (md.Stall_EX === 1'b1 && stall_cycles < 100) begin
         stall_cycles++;
         @(posedge clk); #1;
      end
      vectors++;
      if (stall_cycles !== 33) begin
         miscompares++;
         $display("FAIL read_stall_cycles: got %0d, expected 33", stall_cycles);
      end
      e = sb.pop_front();
      vectors++;
      if (md.MdOut_EX !== e[31:0]) begin
         miscompares++;
         $display("FAIL read_after_stall: got %h, expected %h", md.MdOut_EX, e[31:0]);
      end
      md.RdLo_ME = 1'b0;
      read_hilo(hi, lo);
      vectors++;
      if (hi !== e[63:32]) begin
         miscompares++;
         $display("FAIL read_stall_hi: got %h, expected %h", hi, e[63:32]);
      end
   endtask

   task automatic test_flush();
      logic [31:0] hi;
      logic [31:0] lo;
      run_op(2'b11, 32'd7, 32'd3, 64'h0000_0001_0000_0002, 1'b0, "divu_preload");
      md.Start_ME = 1'b1;
      md.MdOp_ME  = 2'b11;
      md.SrcA_ME  = 32'd100;
      md.SrcB_ME  = 32'd3;
      @(posedge clk); #1;
      md.Start_ME = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      vectors++;
      if (md.Busy_EX !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_busy_before: got %b, expected 1", md.Busy_EX);
      end
      md.flush = 1'b1;
      @(posedge clk); #1;
      md.flush = 1'b0;
      vectors++;
      if (md.Busy_EX !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_busy_after: got %b, expected 0", md.Busy_EX);
      end
      read_hilo(hi, lo);
      vectors++;
      if (hi !== 32'd1 || lo !== 32'd2) begin
         miscompares++;
         $display("FAIL flush_hilo_kept: got %h/%h, expected 00000001/00000002", hi, lo);
      end
      md.Start_ME = 1'b1;
      md.flush    = 1'b1;
      @(posedge clk); #1;
      md.Start_ME = 1'b0;
      md.flush    = 1'b0;
      vectors++;
      if (md.Busy_EX !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_blocks_start: got busy %b, expected 0", md.Busy_EX);
      end
      repeat (35) begin
         @(posedge clk); #1;
      end
      read_hilo(hi, lo);
      vectors++;
      if (hi !== 32'd1 || lo !== 32'd2) begin
         miscompares++;
         $display("FAIL flush_hilo_late: got %h/%h, expected 00000001/00000002", hi, lo);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] hi;
      logic [31:0] lo;
      md.Start_ME = 1'b1;
      md.MdOp_ME  = 2'b00;
      md.SrcA_ME  = 32'd12345;
      md.SrcB_ME  = 32'hFFFF_FFF9;
      @(posedge clk); #1;
      md.Start_ME = 1'b0;
      repeat (19) begin
         @(posedge clk); #1;
      end
      vectors++;
      if (md.Busy_EX !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_busy_before: got %b, expected 1", md.Busy_EX);
      end
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (md.Busy_EX !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_busy_async: got %b, expected 0", md.Busy_EX);
      end
      read_hilo(hi, lo);
      vectors++;
      if (hi !== 32'h0 || lo !== 32'h0) begin
         miscompares++;
         $display("FAIL midreset_hilo_async: got %h/%h, expected 00000000/00000000", hi, lo);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      md.Start_ME = 1'b1;
      md.AnyStall = 1'b1;
      @(posedge clk); #1;
      md.Start_ME = 1'b0;
      md.AnyStall = 1'b0;
      vectors++;
      if (md.Busy_EX !== 1'b0) begin
         miscompares++;
         $display("FAIL anystall_blocks_start: got busy %b, expected 0", md.Busy_EX);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 8; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
         if (i == 5) b = 32'h0;
         if (i == 6) begin a = 32'h8000_0000; b = 32'h0000_0003; op = 2'b10; end
         run_op(op, a, b, model(op, a, b), 1'(i % 2), "back_to_back");
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_mul_div_basic();
      test_div_special();
      test_read_stall();
      test_flush();
      test_reset_mid_op();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
